// File: rtl/cfeb_seq_pkg.sv
// Shared constants, counter widths and FSM state encoding for the CFEB
// readout push sequencer.
package cfeb_seq_pkg;

    localparam int NWORDS_DFLT = 96;
    localparam int GAP_DFLT    = 6;
    localparam int XGAP_DFLT   = 12;
    localparam int PDLY_DFLT   = 6;
    localparam int CDLY_DFLT   = 3;

    localparam int WCNT_W = 7;
    localparam int BCNT_W = 4;
    localparam int XCNT_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_GAP  = 3'd2,
        ST_LAST = 3'd3,
        ST_XGAP = 3'd4,
        ST_XFER = 3'd5,
        ST_TAIL = 3'd6
    } state_e;

endpackage

// File: rtl/cfeb_push_seq_if.sv
// Request/status and CPLD strobe bundle between the readout FSM, the
// sequencer and the CFEB block CPLD pins.
interface cfeb_push_seq_if
    import cfeb_seq_pkg::*;
();
    logic              START;
    logic [BCNT_W-1:0] NBLK;
    logic [XCNT_W-1:0] NXL;
    logic              BUSY;
    logic              PUSH;
    logic              LASTWORD;
    logic              XLOAD;
    logic              SENDCHECK;
    logic              DONE;

    modport master (
        output START, NBLK, NXL,
        input  BUSY, PUSH, LASTWORD, XLOAD, SENDCHECK, DONE
    );

    modport slave (
        input  START, NBLK, NXL,
        output BUSY, PUSH, LASTWORD, XLOAD, SENDCHECK, DONE
    );
endinterface

// File: rtl/cfeb_sendcheck_gen.sv
// Derives the CPLD SENDCHECK window from PUSH/XLOAD history:
// SENDCHECK(n) = !PUSH(n-CDLY) & PUSH(n-PDLY-CDLY) & !XLOAD(n-PDLY-CDLY).
module cfeb_sendcheck_gen
    import cfeb_seq_pkg::*;
#(
    parameter int PDLY = PDLY_DFLT,
    parameter int CDLY = CDLY_DFLT
) (
    input  logic CLK,
    input  logic RST,
    input  logic PUSH,
    input  logic XLOAD,
    output logic SENDCHECK
);

    logic [PDLY-1:0] sr_p;
    logic [CDLY-1:0] sr_c;
    logic            pre_chk;
    logic            tr;

    assign pre_chk = PUSH & ~XLOAD;
    assign tr      = ~PUSH & sr_p[PDLY-1];

    // NOTE: the history registers are reset on purpose so an aborted sequence
    // cannot leak a stale check window into the next one.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sr_p <= '0;
            sr_c <= '0;
        end else begin
            sr_p <= {sr_p[PDLY-2:0], pre_chk};
            sr_c <= {sr_c[CDLY-2:0], tr};
        end
    end

    assign SENDCHECK = sr_c[CDLY-1];

endmodule

// File: rtl/cfeb_push_seq.sv
// CFEB readout sequencer: N data blocks of PUSH, a LASTWORD phase, an
// optional XLOAD burst and a drain tail, with all CPLD strobes registered.
module cfeb_push_seq
    import cfeb_seq_pkg::*;
#(
    parameter int NWORDS = NWORDS_DFLT,
    parameter int GAP    = GAP_DFLT,
    parameter int XGAP   = XGAP_DFLT,
    parameter int PDLY   = PDLY_DFLT,
    parameter int CDLY   = CDLY_DFLT
) (
    input  logic           CLK,
    input  logic           RST,
    cfeb_push_seq_if.slave bus
);

    localparam logic [WCNT_W-1:0] WORDS_M1 = WCNT_W'(NWORDS - 1);
    localparam logic [WCNT_W-1:0] GAP_M1   = WCNT_W'(GAP - 1);
    localparam logic [WCNT_W-1:0] XGAP_M1  = WCNT_W'(XGAP - 1);

    state_e            state,    state_nxt;
    logic [WCNT_W-1:0] wcnt,     wcnt_nxt;
    logic [BCNT_W-1:0] bcnt,     bcnt_nxt;
    logic [XCNT_W-1:0] xcnt,     xcnt_nxt;
    logic [XCNT_W-1:0] nxl_q,    nxl_nxt;
    logic              done_nxt;

    logic busy_q, push_q, lastword_q, xload_q, done_q;
    logic sendcheck;

    // NOTE: every signal gets a default before the case so no latch can be
    // inferred on paths that leave it unassigned.
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        bcnt_nxt  = bcnt;
        xcnt_nxt  = xcnt;
        nxl_nxt   = nxl_q;
        done_nxt  = 1'b0;

        unique case (state)
            ST_IDLE: begin
                // A START landing on the DONE cycle belongs to the old sequence.
                if (bus.START && !done_q) begin
                    nxl_nxt = bus.NXL;
                    if (bus.NBLK != '0) begin
                        state_nxt = ST_DATA;
                        wcnt_nxt  = WORDS_M1;
                        bcnt_nxt  = bus.NBLK - 1'b1;
                    end else if (bus.NXL != '0) begin
                        state_nxt = ST_XGAP;
                        wcnt_nxt  = XGAP_M1;
                    end else begin
                        state_nxt = ST_TAIL;
                        wcnt_nxt  = GAP_M1;
                    end
                end
            end
            ST_DATA: begin
                if (wcnt == '0) begin
                    wcnt_nxt = GAP_M1;
                    if (bcnt != '0) begin
                        state_nxt = ST_GAP;
                        bcnt_nxt  = bcnt - 1'b1;
                    end else begin
                        state_nxt = ST_LAST;
                    end
                end else begin
                    wcnt_nxt = wcnt - 1'b1;
                end
            end
            ST_GAP: begin
                if (wcnt == '0) begin
                    state_nxt = ST_DATA;
                    wcnt_nxt  = WORDS_M1;
                end else begin
                    wcnt_nxt = wcnt - 1'b1;
                end
            end
            ST_LAST: begin
                if (wcnt == '0) begin
                    if (nxl_q != '0) begin
                        state_nxt = ST_XGAP;
                        wcnt_nxt  = XGAP_M1;
                    end else begin
                        state_nxt = ST_TAIL;
                        wcnt_nxt  = GAP_M1;
                    end
                end else begin
                    wcnt_nxt = wcnt - 1'b1;
                end
            end
            ST_XGAP: begin
                if (wcnt == '0) begin
                    state_nxt = ST_XFER;
                    xcnt_nxt  = nxl_q - 1'b1;
                end else begin
                    wcnt_nxt = wcnt - 1'b1;
                end
            end
            ST_XFER: begin
                if (xcnt == '0) begin
                    state_nxt = ST_TAIL;
                    wcnt_nxt  = GAP_M1;
                end else begin
                    xcnt_nxt = xcnt - 1'b1;
                end
            end
            ST_TAIL: begin
                if (wcnt == '0) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    wcnt_nxt = wcnt - 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            wcnt       <= '0;
            bcnt       <= '0;
            xcnt       <= '0;
            nxl_q      <= '0;
            busy_q     <= 1'b0;
            push_q     <= 1'b0;
            lastword_q <= 1'b0;
            xload_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            wcnt       <= wcnt_nxt;
            bcnt       <= bcnt_nxt;
            xcnt       <= xcnt_nxt;
            nxl_q      <= nxl_nxt;
            busy_q     <= (state_nxt != ST_IDLE);
            push_q     <= (state_nxt == ST_DATA) || (state_nxt == ST_XFER);
            lastword_q <= (state_nxt == ST_LAST);
            xload_q    <= (state_nxt == ST_XFER);
            done_q     <= done_nxt;
        end
    end

    cfeb_sendcheck_gen #(
        .PDLY (PDLY),
        .CDLY (CDLY)
    ) u_sendcheck_gen (
        .CLK       (CLK),
        .RST       (RST),
        .PUSH      (push_q),
        .XLOAD     (xload_q),
        .SENDCHECK (sendcheck)
    );

    assign bus.BUSY      = busy_q;
    assign bus.PUSH      = push_q;
    assign bus.LASTWORD  = lastword_q;
    assign bus.XLOAD     = xload_q;
    assign bus.SENDCHECK = sendcheck;
    assign bus.DONE      = done_q;

endmodule

// File: tb/tb_cfeb_push_seq.sv
// Self-checking bench: expected strobe waveforms are built from the phase
// lengths of each requested sequence and compared cycle by cycle.
module tb_cfeb_push_seq;
    import cfeb_seq_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    cfeb_push_seq_if bus ();

    cfeb_push_seq dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Vector layout: {BUSY, PUSH, LASTWORD, XLOAD, SENDCHECK, DONE}
    logic [5:0] exp_v [0:4095];
    int         exp_len;
    int         falls [$];

    function automatic logic [5:0] outs();
        return {bus.BUSY, bus.PUSH, bus.LASTWORD, bus.XLOAD, bus.SENDCHECK, bus.DONE};
    endfunction

    task automatic check(input string tag, input int idx, input logic [5:0] obs,
                         input logic [5:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, idx, obs, req);
        end
    endtask

    task automatic append(input int n, input logic p, input logic l, input logic x);
        for (int k = 0; k < n; k++) begin
            exp_v[exp_len] = {1'b1, p, l, x, 1'b0, 1'b0};
            exp_len++;
        end
    endtask

    // Expected waveform, index 0 = first cycle after START is sampled.
    task automatic build(input int nblk, input int nxl);
        for (int i = 0; i < 4096; i++) exp_v[i] = '0;
        exp_len = 0;
        falls.delete();
        for (int b = 0; b < nblk; b++) begin
            append(96, 1'b1, 1'b0, 1'b0);
            falls.push_back(exp_len);
            if (b < nblk - 1) append(6, 1'b0, 1'b0, 1'b0);
        end
        if (nblk > 0) append(6, 1'b0, 1'b1, 1'b0);
        if (nxl > 0) begin
            append(12, 1'b0, 1'b0, 1'b0);
            append(nxl, 1'b1, 1'b0, 1'b1);
        end
        append(6, 1'b0, 1'b0, 1'b0);
        exp_v[exp_len] = 6'b000001;
        exp_len += 5;
        // Each data block gives a 6-cycle check window 3 cycles after PUSH falls.
        foreach (falls[j])
            for (int k = 3; k < 9; k++) exp_v[falls[j] + k][1] = 1'b1;
    endtask

    task automatic run_seq(input string tag, input int nblk, input int nxl,
                           input bit spurious, input int rst_at);
        build(nblk, nxl);
        bus.START = 1'b1;
        bus.NBLK  = 4'(nblk);
        bus.NXL   = 6'(nxl);
        for (int i = 0; i < exp_len; i++) begin
            @(posedge CLK);
            #1;
            bus.START = 1'b0;
            check(tag, i, outs(), exp_v[i]);
            if (i == rst_at) begin
                RST = 1'b1;
                for (int k = 0; k < 14; k++) begin
                    @(posedge CLK);
                    #1;
                    RST = 1'b0;
                    check({tag, "_abort"}, k, outs(), 6'b0);
                end
                return;
            end
            if (spurious && (i == 9 || i == 19 || i == exp_len - 6)) begin
                bus.START = 1'b1;
                bus.NBLK  = 4'($urandom_range(1, 15));
                bus.NXL   = 6'($urandom_range(1, 63));
            end
        end
    endtask

    initial begin
        bus.START = 1'b0;
        bus.NBLK  = '0;
        bus.NXL   = '0;
        RST       = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("reset", 0, outs(), 6'b0);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check("idle", 0, outs(), 6'b0);

        run_seq("nblk4", 4, 0, 1'b0, -1);
        run_seq("nblk1_nxl18", 1, 18, 1'b0, -1);
        run_seq("nblk0_nxl48", 0, 48, 1'b0, -1);
        run_seq("empty", 0, 0, 1'b0, -1);
        // Word 50 of block 2: block 1 (96) + gap (6) + 49 words in.
        run_seq("rst_mid", 3, 0, 1'b0, 151);
        run_seq("after_rst", 1, 0, 1'b0, -1);
        run_seq("ignore_start", 1, 0, 1'b1, -1);

        RST       = 1'b1;
        bus.START = 1'b1;
        bus.NBLK  = 4'd2;
        bus.NXL   = 6'd5;
        @(posedge CLK);
        #1;
        RST       = 1'b0;
        bus.START = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK);
            #1;
            check("start_with_rst", k, outs(), 6'b0);
        end

        for (int r = 0; r < 4; r++)
            run_seq("random", $urandom_range(0, 3), $urandom_range(0, 63), 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
